// File: rtl/lock_pkg.sv
// Shared types and constants for the digit combination lock controller.
package lock_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROGRAM,
    ST_LOCKOUT
  } lock_state_t;
endpackage

// File: rtl/bcd_entry.sv
// BCD digit entry: per-digit increment with 9->0 wrap and digit commit into a buffer.
// Digit 0 lives in the most significant nibble of the buffer.
module bcd_entry
  import lock_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      active,
  input  logic                      btn_inc,
  input  logic                      btn_next,
  output logic [2:0]                digit_idx,
  output logic [DIGIT_W-1:0]        digit_val,
  output logic [DIGIT_W*DIGITS-1:0] entry_buf,
  output logic [DIGIT_W*DIGITS-1:0] entry_nxt,
  output logic                      last_digit
);

  logic commit;

  assign last_digit = (digit_idx == 3'(DIGITS - 1));
  assign commit     = active && btn_next;

  always_comb begin
    entry_nxt = entry_buf;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == 3'(i)) entry_nxt[DIGIT_W*(DIGITS-1-i) +: DIGIT_W] = digit_val;
    end
  end

  // The buffer takes the commit even when the FSM clears idx/val on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx <= '0;
      digit_val <= '0;
      entry_buf <= '0;
    end else begin
      if (commit) entry_buf <= entry_nxt;
      if (clear) begin
        digit_idx <= '0;
        digit_val <= '0;
      end else if (commit) begin
        digit_val <= '0;
        digit_idx <= last_digit ? 3'd0 : digit_idx + 3'd1;
      end else if (active && btn_inc) begin
        digit_val <= (digit_val == BCD_MAX) ? '0 : digit_val + 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_lock_ctrl.sv
// Digit combination lock: code entry, compare, open/relock, reprogramming and
// timed lockout after repeated mismatches.
//   state      | meaning
//   ST_ENTRY   | user entering digits of a candidate code
//   ST_CHECK   | one-cycle compare of entry against stored code
//   ST_OPEN    | code matched, lock open
//   ST_PROGRAM | entering a new code (reached only from OPEN)
//   ST_LOCKOUT | too many mismatches, all buttons ignored until timer expires
module digit_lock_ctrl
  import lock_pkg::*;
#(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                  MAX_FAILS      = 3,
  parameter logic [31:0]         LOCKOUT_CYCLES = 32'd100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_inc,
  input  logic               btn_next,
  input  logic               btn_set,
  output logic               unlocked,
  output logic               lockout,
  output logic               err,
  output logic [2:0]         digit_idx,
  output logic [DIGIT_W-1:0] digit_val
);

  localparam int CODE_W = DIGIT_W * DIGITS;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LK_W   = $clog2(LOCKOUT_CYCLES + 32'd1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
  localparam logic [LK_W-1:0]   LK_LOAD   = LK_W'(LOCKOUT_CYCLES - 32'd1);

  lock_state_t        state_q, state_d;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  entry_buf, entry_nxt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [LK_W-1:0]    lk_cnt;
  logic               last_digit, active, clear, match;

  assign active = (state_q == ST_ENTRY) || (state_q == ST_PROGRAM);
  assign clear  = (state_d != state_q) && ((state_d == ST_ENTRY) || (state_d == ST_PROGRAM));
  assign match  = (entry_buf == code_q);

  bcd_entry #(.DIGITS(DIGITS)) u_entry (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .active     (active),
    .btn_inc    (btn_inc),
    .btn_next   (btn_next),
    .digit_idx  (digit_idx),
    .digit_val  (digit_val),
    .entry_buf  (entry_buf),
    .entry_nxt  (entry_nxt),
    .last_digit (last_digit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY:   if (btn_next && last_digit) state_d = ST_CHECK;
      ST_CHECK: begin
        if (match)                      state_d = ST_OPEN;
        else if (fail_cnt >= FAIL_LAST) state_d = ST_LOCKOUT;
        else                            state_d = ST_ENTRY;
      end
      ST_OPEN: begin
        if (btn_set)       state_d = ST_PROGRAM;
        else if (btn_next) state_d = ST_ENTRY;
      end
      ST_PROGRAM: if (btn_next && last_digit) state_d = ST_ENTRY;
      ST_LOCKOUT: if (lk_cnt == '0) state_d = ST_ENTRY;
      default:    state_d = ST_ENTRY;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTRY;
      code_q   <= DEFAULT_CODE;
      fail_cnt <= '0;
      lk_cnt   <= '0;
      unlocked <= 1'b0;
      lockout  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      unlocked <= (state_d == ST_OPEN);
      lockout  <= (state_d == ST_LOCKOUT);
      err      <= (state_q == ST_CHECK) && !match;

      if ((state_q == ST_PROGRAM) && btn_next && last_digit) code_q <= entry_nxt;

      if (state_q == ST_CHECK)
        fail_cnt <= match ? '0 : fail_cnt + 1'b1;
      else if ((state_q == ST_LOCKOUT) && (state_d == ST_ENTRY))
        fail_cnt <= '0;

      if ((state_q != ST_LOCKOUT) && (state_d == ST_LOCKOUT))
        lk_cnt <= LK_LOAD;
      else if ((state_q == ST_LOCKOUT) && (lk_cnt != '0))
        lk_cnt <= lk_cnt - 1'b1;
    end
  end

endmodule
